// File: rtl/spart_bus_arbiter.sv
// Round-robin arbiter sharing the SPART processor bus among NUM_REQ masters.
// Optional ready-wait timeout is enabled with `define SPART_ARB_TIMEOUT_EN.
module spart_bus_arbiter #(
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [NUM_REQ-1:0]     req_rw,
   input  logic [2*NUM_REQ-1:0]   req_addr,
   input  logic [8*NUM_REQ-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]     ack,
   output logic [NUM_REQ-1:0]     err,
   output logic [7:0]             rdata,
   output logic                   iocs,
   output logic                   iorw,
   output logic [1:0]             ioaddr,
   inout  wire  [7:0]             databus,
   input  logic                   rda,
   input  logic                   tbr
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {IDLE, WAIT_RDY, ACCESS, ACK} state_t;

   state_t          state, state_nxt;
   logic [PW-1:0]   rr_ptr;
   logic [PW-1:0]   grant_q;
   logic [PW-1:0]   grant_sel;
   logic            found;
   logic            rw_q;
   logic [1:0]      addr_q;
   logic [7:0]      wdata_q;
   logic            ready;
   logic            timeout_hit;

   // First pending requester at or after rr_ptr, wrapping around.
   always_comb begin : arb
      int            k;
      logic [PW-1:0] idx;
      found     = 1'b0;
      grant_sel = '0;
      k         = 0;
      idx       = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         k   = (int'(rr_ptr) + i) % NUM_REQ;
         idx = PW'(k);
         if (!found && req[idx]) begin
            found     = 1'b1;
            grant_sel = idx;
         end
      end
   end

   // Only buffer accesses depend on SPART status; register accesses are always ready.
   assign ready = (addr_q != 2'b00) ? 1'b1 : (rw_q ? rda : tbr);

`ifdef SPART_ARB_TIMEOUT_EN
   localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [TW-1:0] timer;
   logic          err_q;

   assign timeout_hit = (timer == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer <= '0;
         err_q <= 1'b0;
      end else if (state == IDLE && found) begin
         timer <= '0;
         err_q <= 1'b0;
      end else if (state == WAIT_RDY) begin
         timer <= timer + 1'b1;
         if (!ready && timeout_hit) err_q <= 1'b1;
      end
   end

   always_comb begin
      err = '0;
      for (int i = 0; i < NUM_REQ; i++)
         err[i] = (state == ACK) && err_q && (grant_q == PW'(i));
   end
`else
   assign timeout_hit = 1'b0;
   assign err         = '0;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (found) state_nxt = WAIT_RDY;
         WAIT_RDY: begin
            if (ready)            state_nxt = ACCESS;
            else if (timeout_hit) state_nxt = ACK;
         end
         ACCESS:   state_nxt = ACK;
         ACK:      state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         rr_ptr  <= '0;
         grant_q <= '0;
         rw_q    <= 1'b1;
         addr_q  <= 2'b00;
         wdata_q <= 8'h00;
         rdata   <= 8'h00;
      end else begin
         state <= state_nxt;
         if (state == IDLE && found) begin
            grant_q <= grant_sel;
            rw_q    <= req_rw[grant_sel];
            addr_q  <= req_addr[2*grant_sel +: 2];
            wdata_q <= req_wdata[8*grant_sel +: 8];
         end
         if (state == ACCESS && rw_q) rdata <= databus;
         if (state == ACK)
            rr_ptr <= (grant_q == PW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
      end
   end

   assign iocs    = (state == ACCESS);
   assign iorw    = iocs ? rw_q : 1'b1;
   assign ioaddr  = iocs ? addr_q : 2'b00;
   assign databus = (iocs && !rw_q) ? wdata_q : 8'hzz;

   always_comb begin
      ack = '0;
      for (int i = 0; i < NUM_REQ; i++)
         ack[i] = (state == ACK) && (grant_q == PW'(i));
   end

endmodule

// File: tb/tb_spart_bus_arbiter.sv
// Self-checking bench for spart_bus_arbiter: a scoreboard of expected acks and
// expected bus accesses, filled by the driver and drained by a negedge monitor.
module tb_spart_bus_arbiter;

  localparam int NR = 2;
  localparam int TC = 16;
  localparam int EW = 2*NR + 8;  // {ack, err, rdata}
  localparam int BW = 11;        // {iorw, ioaddr, data}

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req, req_rw;
  logic [2*NR-1:0] req_addr;
  logic [8*NR-1:0] req_wdata;
  logic [NR-1:0]   ack, err;
  logic [7:0]      rdata;
  logic            iocs, iorw;
  logic [1:0]      ioaddr;
  wire  [7:0]      databus;
  logic            rda, tbr;
  logic [7:0]      sp_rd_val;

  // SPART model: drives read data during a read access, weak-zero keeper when idle.
  assign databus = (iocs && iorw) ? sp_rd_val : (iocs ? 8'hzz : 8'h00);

  spart_bus_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TC)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_rw(req_rw), .req_addr(req_addr),
    .req_wdata(req_wdata), .ack(ack), .err(err), .rdata(rdata), .iocs(iocs),
    .iorw(iorw), .ioaddr(ioaddr), .databus(databus), .rda(rda), .tbr(tbr)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  logic [EW-1:0] exp_q[$];
  logic [BW-1:0] bus_q[$];
  logic [7:0]    last_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: every ack is matched against the head of exp_q, every access against bus_q.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [BW-1:0] b;
    if (|ack) begin
      if (exp_q.size() == 0) check("ack_unexp", 32'(ack), 32'h0);
      else begin
        e = exp_q.pop_front();
        check("ack", 32'(ack), 32'(e[EW-1 -: NR]));
        check("err", 32'(err), 32'(e[EW-NR-1 -: NR]));
        check("rdata", 32'(rdata), 32'(e[7:0]));
      end
    end else if (|err) begin
      check("err_no_ack", 32'(err), 32'h0);
    end
    if (iocs) begin
      if (bus_q.size() == 0) check("bus_unexp", 32'(iocs), 32'h0);
      else begin
        b = bus_q.pop_front();
        check("bus_access", 32'({iorw, ioaddr, databus}), 32'(b));
      end
    end else begin
      check("bus_idle", 32'({iorw, ioaddr, databus}), 32'({1'b1, 2'b00, 8'h00}));
    end
  end

  task automatic start_req(input int idx, input logic rw, input logic [1:0] addr,
                           input logic [7:0] wdata, input logic [7:0] rd, input logic to_err);
    logic [NR-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    if (to_err) begin
      exp_q.push_back({oh, oh, last_rd});
    end else if (rw) begin
      last_rd = rd;
      exp_q.push_back({oh, {NR{1'b0}}, rd});
      bus_q.push_back({1'b1, addr, rd});
    end else begin
      exp_q.push_back({oh, {NR{1'b0}}, last_rd});
      bus_q.push_back({1'b0, addr, wdata});
    end
    req_rw[idx]           = rw;
    req_addr[2*idx +: 2]  = addr;
    req_wdata[8*idx +: 8] = wdata;
    req[idx]              = 1'b1;
  endtask

  // Counts rising edges until ack[idx]; drops the request and steps into IDLE.
  task automatic wait_ack(input int idx, output int cyc);
    cyc = 0;
    while (1) begin
      @(posedge clk); #1;
      cyc++;
      if (ack[idx]) break;
      if (cyc >= 100) begin
        check("ack_timeout", 32'(ack), 32'(1 << idx));
        break;
      end
    end
    req[idx] = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int cyc, k, last_cyc;
    int idx;
    logic rw;
    logic [1:0] addr;
    logic [7:0] v;
    rst_n = 1'b0; req = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
    rda = 1'b0; tbr = 1'b0; sp_rd_val = 8'h00; last_rd = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_iocs", 32'(iocs), 32'h0);
    check("rst_iorw", 32'(iorw), 32'h1);
    check("rst_ioaddr", 32'(ioaddr), 32'h0);
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_rdata", 32'(rdata), 32'h0);
    check("rst_databus", 32'(databus), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Divisor write needs no status: 3-cycle latency even with tbr low.
    start_req(0, 1'b0, 2'b10, 8'h8B, 8'h00, 1'b0);
    wait_ack(0, cyc);
    check("lat_div_wr", 32'(cyc), 32'd3);

    // Buffer write stalls on tbr; access follows the cycle after tbr rises.
    start_req(1, 1'b0, 2'b00, 8'h41, 8'h00, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    tbr = 1'b1;
    wait_ack(1, cyc);
    check("lat_after_tbr", 32'(cyc), 32'd2);
    tbr = 1'b0;

    // Buffer read ignores tbr, waits for an rda pulse.
    sp_rd_val = 8'h5A;
    start_req(1, 1'b1, 2'b00, 8'h00, 8'h5A, 1'b0);
    tbr = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rda = 1'b1;
    @(posedge clk); #1;
    rda = 1'b0;
    tbr = 1'b0;
    wait_ack(1, cyc);
    check("lat_after_rda", 32'(cyc), 32'd1);

    // Both requesters held: grants alternate and acks are 4 cycles apart.
    v = 8'($urandom_range(0, 255));
    sp_rd_val = v;
    start_req(0, 1'b1, 2'b01, 8'h00, v, 1'b0);
    start_req(1, 1'b1, 2'b01, 8'h00, v, 1'b0);
    start_req(0, 1'b1, 2'b01, 8'h00, v, 1'b0);
    start_req(1, 1'b1, 2'b01, 8'h00, v, 1'b0);
    cyc = 0; k = 0; last_cyc = 0;
    while (k < 4 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (|ack) begin
        check("rr_order", 32'(ack), 32'(1 << (k % 2)));
        if (k == 0) check("rr_first_lat", 32'(cyc), 32'd3);
        else        check("rr_spacing", 32'(cyc - last_cyc), 32'd4);
        last_cyc = cyc;
        k++;
        if (k == 4) req = '0;
      end
    end
    check("rr_count", 32'(k), 32'd4);
    req = '0;
    @(posedge clk); #1;

    // Move rr_ptr to 1, then reset while requester 1 waits on tbr.
    start_req(0, 1'b0, 2'b11, 8'($urandom_range(0, 255)), 8'h00, 1'b0);
    wait_ack(0, cyc);
    start_req(1, 1'b0, 2'b00, 8'h77, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_iocs", 32'(iocs), 32'h0);
    check("mid_rst_ack", 32'(ack), 32'h0);
    check("mid_rst_databus", 32'(databus), 32'h0);
    check("mid_rst_rdata", 32'(rdata), 32'h0);
    exp_q.delete();
    bus_q.delete();
    last_rd = 8'h00;
    req = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    start_req(0, 1'b0, 2'b10, 8'h12, 8'h00, 1'b0);
    start_req(1, 1'b0, 2'b11, 8'h34, 8'h00, 1'b0);
    wait_ack(0, cyc);
    check("post_rst_lat0", 32'(cyc), 32'd3);
    wait_ack(1, cyc);
    check("post_rst_lat1", 32'(cyc), 32'd3);

    // Random traffic with the SPART always ready.
    tbr = 1'b1;
    rda = 1'b1;
    for (int i = 0; i < 8; i++) begin
      idx  = $urandom_range(0, NR - 1);
      rw   = 1'($urandom_range(0, 1));
      addr = 2'($urandom_range(0, 3));
      v    = 8'($urandom_range(0, 255));
      sp_rd_val = v;
      start_req(idx, rw, addr, 8'($urandom_range(0, 255)), v, 1'b0);
      wait_ack(idx, cyc);
      check("rand_lat", 32'(cyc), 32'd3);
    end
    tbr = 1'b0;
    rda = 1'b0;

`ifdef SPART_ARB_TIMEOUT_EN
    // Buffer write with tbr stuck low gives up after TC cycles in WAIT_RDY.
    start_req(0, 1'b0, 2'b00, 8'hC3, 8'h00, 1'b1);
    wait_ack(0, cyc);
    check("timeout_lat", 32'(cyc), 32'(TC + 1));
`endif

    repeat (3) @(posedge clk);
    #1;
    check("exp_q_drained", 32'(exp_q.size()), 32'h0);
    check("bus_q_drained", 32'(bus_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
